// File: rtl/supernova_pkg.sv
// Shared Supernova core types and sizes used by the reorder buffer.
package supernova_pkg;

  localparam int RENAME_WIDTH  = 4;
  localparam int ISSUE_WIDTH   = 4;
  localparam int ROB_ENTRIES   = 128;
  localparam int ROB_IDX_WIDTH = $clog2(ROB_ENTRIES);
  // One extra bit on head/tail so full and empty are distinguishable.
  localparam int ROB_PTR_WIDTH = ROB_IDX_WIDTH + 1;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic        has_exception;
    logic [63:0] pc;
    logic [4:0]  rd_arch;
    logic [6:0]  rd_phys;
    logic [6:0]  rd_phys_old;
    logic        is_store;
    logic [63:0] result_data;
    logic [63:0] trap_cause;
  } rob_entry_t;

  typedef struct packed {
    logic                     valid;
    logic [ROB_IDX_WIDTH-1:0] idx;
    logic [63:0]              data;
    logic                     exc;
    logic [63:0]              cause;
  } rob_wb_t;

  typedef struct packed {
    logic       valid;
    rob_entry_t entry;
  } rob_commit_t;

  // Slot index reached by stepping 'off' entries past a pointer, wrapping modulo ROB_ENTRIES.
  function automatic logic [ROB_IDX_WIDTH-1:0] rob_idx_add(input logic [ROB_PTR_WIDTH-1:0] ptr,
                                                           input int unsigned off);
    return ptr[ROB_IDX_WIDTH-1:0] + ROB_IDX_WIDTH'(off);
  endfunction

endpackage

// File: rtl/supernova_rob_commit_sel.sv
// Picks how many head-window entries retire this cycle and whether the head traps.
module supernova_rob_commit_sel
  import supernova_pkg::*;
#(
  parameter int COMMIT_WIDTH = 4
) (
  input  logic [COMMIT_WIDTH-1:0]  win_valid_i,
  input  logic [COMMIT_WIDTH-1:0]  win_done_i,
  input  logic [COMMIT_WIDTH-1:0]  win_exc_i,
  output logic [COMMIT_WIDTH-1:0]  commit_mask_o,
  output logic [ROB_PTR_WIDTH-1:0] commit_cnt_o,
  output logic                     trap_o
);

  logic run_s;

  // Retirement stops at the first entry that is empty, still executing or faulted.
  always_comb begin
    commit_mask_o = '0;
    commit_cnt_o  = '0;
    run_s         = 1'b1;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      run_s            = run_s & win_valid_i[k] & win_done_i[k] & ~win_exc_i[k];
      commit_mask_o[k] = run_s;
      if (run_s) begin
        commit_cnt_o = commit_cnt_o + ROB_PTR_WIDTH'(1);
      end else begin
        commit_cnt_o = commit_cnt_o;
      end
    end
    trap_o = win_valid_i[0] & win_done_i[0] & win_exc_i[0];
  end

endmodule

// File: rtl/supernova_rob.sv
// Reorder buffer: in-order allocate, out-of-order complete, in-order retire, precise trap.
module supernova_rob
  import supernova_pkg::*;
#(
  parameter int ALLOC_WIDTH  = RENAME_WIDTH,
  parameter int COMMIT_WIDTH = 4,
  parameter int WB_PORTS     = ISSUE_WIDTH
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       flush_i,
  input  logic [ALLOC_WIDTH-1:0]                     alloc_valid_i,
  input  rob_entry_t [ALLOC_WIDTH-1:0]               alloc_entry_i,
  output logic                                       alloc_ready_o,
  output logic [ALLOC_WIDTH-1:0][ROB_IDX_WIDTH-1:0]  alloc_idx_o,
  input  logic [WB_PORTS-1:0]                        wb_valid_i,
  input  logic [WB_PORTS-1:0][ROB_IDX_WIDTH-1:0]     wb_idx_i,
  input  logic [WB_PORTS-1:0][63:0]                  wb_data_i,
  input  logic [WB_PORTS-1:0]                        wb_exc_i,
  input  logic [WB_PORTS-1:0][63:0]                  wb_cause_i,
  output logic [COMMIT_WIDTH-1:0]                    commit_valid_o,
  output rob_entry_t [COMMIT_WIDTH-1:0]              commit_entry_o,
  output logic                                       trap_valid_o,
  output logic [63:0]                                trap_pc_o,
  output logic [63:0]                                trap_cause_o,
  output logic [ROB_PTR_WIDTH-1:0]                   count_o
);

  rob_entry_t               entries_q [ROB_ENTRIES];
  rob_entry_t               entries_d [ROB_ENTRIES];
  logic [ROB_PTR_WIDTH-1:0] head_q, head_d;
  logic [ROB_PTR_WIDTH-1:0] tail_q, tail_d;

  logic [ROB_PTR_WIDTH-1:0] count_s;
  logic [ROB_PTR_WIDTH-1:0] free_s;
  logic [ROB_PTR_WIDTH-1:0] alloc_n_s;
  logic                     alloc_fire_s;
  rob_wb_t                  wb_s [WB_PORTS];

  logic [COMMIT_WIDTH-1:0]  win_valid_s, win_done_s, win_exc_s;
  logic [COMMIT_WIDTH-1:0]  commit_mask_s;
  logic [ROB_PTR_WIDTH-1:0] commit_cnt_s;
  logic                     head_trap_s;
  rob_entry_t               head_entry_s;

  // Occupancy, free space and the allocation handshake.
  always_comb begin
    count_s       = tail_q - head_q;
    free_s        = ROB_PTR_WIDTH'(ROB_ENTRIES) - count_s;
    alloc_ready_o = (free_s >= ROB_PTR_WIDTH'(ALLOC_WIDTH)) & ~trap_valid_o & ~flush_i;
    alloc_n_s     = '0;
    for (int i = 0; i < ALLOC_WIDTH; i++) begin
      alloc_idx_o[i] = rob_idx_add(tail_q, i);
      if (alloc_valid_i[i]) begin
        alloc_n_s = alloc_n_s + ROB_PTR_WIDTH'(1);
      end else begin
        alloc_n_s = alloc_n_s;
      end
    end
    alloc_fire_s = alloc_ready_o & (|alloc_valid_i);
    count_o      = count_s;
  end

  // Bundle writeback ports and gather the status bits of the retirement window.
  always_comb begin
    for (int p = 0; p < WB_PORTS; p++) begin
      wb_s[p].valid = wb_valid_i[p];
      wb_s[p].idx   = wb_idx_i[p];
      wb_s[p].data  = wb_data_i[p];
      wb_s[p].exc   = wb_exc_i[p];
      wb_s[p].cause = wb_cause_i[p];
    end
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      win_valid_s[k] = entries_q[rob_idx_add(head_q, k)].valid;
      win_done_s[k]  = entries_q[rob_idx_add(head_q, k)].done;
      win_exc_s[k]   = entries_q[rob_idx_add(head_q, k)].has_exception;
    end
    head_entry_s = entries_q[head_q[ROB_IDX_WIDTH-1:0]];
  end

  supernova_rob_commit_sel #(
    .COMMIT_WIDTH (COMMIT_WIDTH)
  ) u_commit_sel (
    .win_valid_i   (win_valid_s),
    .win_done_i    (win_done_s),
    .win_exc_i     (win_exc_s),
    .commit_mask_o (commit_mask_s),
    .commit_cnt_o  (commit_cnt_s),
    .trap_o        (head_trap_s)
  );

  // Retire and trap outputs; an external flush suppresses both in the same cycle.
  always_comb begin
    commit_valid_o = flush_i ? '0 : commit_mask_s;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      commit_entry_o[k] = commit_valid_o[k] ? entries_q[rob_idx_add(head_q, k)] : '0;
    end
    trap_valid_o = head_trap_s & ~flush_i;
    trap_pc_o    = trap_valid_o ? head_entry_s.pc         : 64'h0;
    trap_cause_o = trap_valid_o ? head_entry_s.trap_cause : 64'h0;
  end

  // Next-state: flush/trap empties the buffer, otherwise retire, complete, then allocate.
  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    if (flush_i || trap_valid_o) begin
      for (int i = 0; i < ROB_ENTRIES; i++) begin
        entries_d[i].valid = 1'b0;
      end
      head_d = '0;
      tail_d = '0;
    end else begin
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        if (commit_valid_o[k]) begin
          entries_d[rob_idx_add(head_q, k)].valid = 1'b0;
        end else begin
        end
      end
      head_d = head_q + commit_cnt_s;
      // Completions only land on entries that were live before this edge.
      for (int p = 0; p < WB_PORTS; p++) begin
        if (wb_s[p].valid && entries_q[wb_s[p].idx].valid) begin
          entries_d[wb_s[p].idx].done          = 1'b1;
          entries_d[wb_s[p].idx].result_data   = wb_s[p].data;
          entries_d[wb_s[p].idx].has_exception = wb_s[p].exc;
          entries_d[wb_s[p].idx].trap_cause    = wb_s[p].cause;
        end else begin
        end
      end
      for (int i = 0; i < ALLOC_WIDTH; i++) begin
        if (alloc_fire_s && alloc_valid_i[i]) begin
          entries_d[rob_idx_add(tail_q, i)]               = alloc_entry_i[i];
          entries_d[rob_idx_add(tail_q, i)].valid         = 1'b1;
          entries_d[rob_idx_add(tail_q, i)].done          = 1'b0;
          entries_d[rob_idx_add(tail_q, i)].has_exception = 1'b0;
        end else begin
        end
      end
      tail_d = tail_q + (alloc_fire_s ? alloc_n_s : ROB_PTR_WIDTH'(0));
    end
  end

  // State registers with synchronous reset of pointers and entry status bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      for (int i = 0; i < ROB_ENTRIES; i++) begin
        entries_q[i].valid         <= 1'b0;
        entries_q[i].done          <= 1'b0;
        entries_q[i].has_exception <= 1'b0;
      end
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      entries_q <= entries_d;
    end
  end

endmodule
